// File: rtl/unidade_controle_multiciclo_pkg.sv
// Shared opcode and time-step encodings for the multicycle processor control unit,
// used by the control unit, the datapath and the bench.
package unidade_controle_multiciclo_pkg;

    typedef enum logic [2:0] {
        MV   = 3'b000,
        MVI  = 3'b001,
        ADD  = 3'b010,
        SUB  = 3'b011,
        MVNZ = 3'b100
    } opcode_e;

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } tstep_e;

    localparam int NUM_REGS = 8;
    localparam int IR_WIDTH = 9;

endpackage

// File: rtl/unidade_controle_multiciclo_dec3to8.sv
// Combinational 3-to-8 one-hot decoder with enable; selects a register from an IR field.
module dec3to8 (
    input  logic [2:0] i_w,
    input  logic       i_en,
    output logic [7:0] o_y
);

    always_comb begin
        o_y = 8'b0;
        if (i_en) begin
            o_y[i_w] = 1'b1;
        end
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Control unit of a multicycle processor: Tstep is the only state, every control
// output is decoded combinationally from Tstep, IR, Run and G_nz.
module unidade_controle_multiciclo
    import unidade_controle_multiciclo_pkg::*;
(
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       Run,
    input  logic [8:0] IR,
    input  logic       G_nz,
    output logic       IRin,
    output logic [7:0] Rin,
    output logic [7:0] Rout,
    output logic       Ain,
    output logic       Gin,
    output logic       Gout,
    output logic       DINout,
    output logic       AddSub,
    output logic       Done,
    output logic [1:0] Tstep
);

    tstep_e     r_tstep;
    tstep_e     w_nextStep;
    opcode_e    w_op;
    logic [7:0] w_xDec;
    logic [7:0] w_yDec;

    assign w_op  = opcode_e'(IR[8:6]);
    assign Tstep = r_tstep;

    // Enabling the decoders from Resetn keeps register selects dark during reset.
    dec3to8 u_decX (
        .i_w  (IR[5:3]),
        .i_en (Resetn),
        .o_y  (w_xDec)
    );

    dec3to8 u_decY (
        .i_w  (IR[2:0]),
        .i_en (Resetn),
        .o_y  (w_yDec)
    );

    always_comb begin
        w_nextStep = T0;
        case (r_tstep)
            T0:      w_nextStep = Run ? T1 : T0;
            T1:      w_nextStep = (w_op == ADD || w_op == SUB) ? T2 : T0;
            T2:      w_nextStep = T3;
            default: w_nextStep = T0;
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            r_tstep <= T0;
        end else begin
            r_tstep <= w_nextStep;
        end
    end

    // Reset gates everything, since T0 alone would still let Run reach IRin.
    always_comb begin
        IRin   = 1'b0;
        Rin    = 8'b0;
        Rout   = 8'b0;
        Ain    = 1'b0;
        Gin    = 1'b0;
        Gout   = 1'b0;
        DINout = 1'b0;
        AddSub = 1'b0;
        Done   = 1'b0;
        if (Resetn) begin
            case (r_tstep)
                T0: IRin = Run;
                T1: begin
                    case (w_op)
                        MV: begin
                            Rout = w_yDec;
                            Rin  = w_xDec;
                            Done = 1'b1;
                        end
                        MVI: begin
                            DINout = 1'b1;
                            Rin    = w_xDec;
                            Done   = 1'b1;
                        end
                        ADD, SUB: begin
                            Rout = w_xDec;
                            Ain  = 1'b1;
                        end
                        MVNZ: begin
                            if (G_nz) begin
                                Rout = w_yDec;
                                Rin  = w_xDec;
                            end
                            Done = 1'b1;
                        end
                        default: Done = 1'b1;
                    endcase
                end
                T2: begin
                    Rout   = w_yDec;
                    Gin    = 1'b1;
                    AddSub = (w_op == SUB);
                end
                default: begin
                    Gout = 1'b1;
                    Rin  = w_xDec;
                    Done = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Directed bench for the multicycle control unit, with a small falling-edge
// datapath model so register results of each instruction can be checked.
module tb_unidade_controle_multiciclo;
    import unidade_controle_multiciclo_pkg::*;

    logic       Clock;
    logic       Resetn;
    logic       Run;
    logic [8:0] IR;
    logic       G_nz;
    logic       IRin;
    logic [7:0] Rin;
    logic [7:0] Rout;
    logic       Ain;
    logic       Gin;
    logic       Gout;
    logic       DINout;
    logic       AddSub;
    logic       Done;
    logic [1:0] Tstep;

    logic [8:0] DIN;
    logic [8:0] R [8];
    logic [8:0] A;
    logic [8:0] G;
    logic [8:0] bus;

    int testCount = 0;
    int failCount = 0;

    unidade_controle_multiciclo dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Run    (Run),
        .IR     (IR),
        .G_nz   (G_nz),
        .IRin   (IRin),
        .Rin    (Rin),
        .Rout   (Rout),
        .Ain    (Ain),
        .Gin    (Gin),
        .Gout   (Gout),
        .DINout (DINout),
        .AddSub (AddSub),
        .Done   (Done),
        .Tstep  (Tstep)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Datapath model: captures on the falling edge, after the controls settle.
    always @(negedge Clock) begin
        bus = 9'd0;
        if (DINout) bus = DIN;
        if (Gout) bus = G;
        for (int i = 0; i < 8; i++) begin
            if (Rout[i]) bus = R[i];
        end
        if (Gin) G = AddSub ? (A - bus) : (A + bus);
        if (Ain) A = bus;
        for (int i = 0; i < 8; i++) begin
            if (Rin[i]) R[i] = bus;
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [22:0] mkCtrl(input logic irin, input logic [7:0] rin,
                                           input logic [7:0] rout, input logic ain,
                                           input logic gin, input logic gout,
                                           input logic dinout, input logic addsub,
                                           input logic done);
        return {irin, rin, rout, ain, gin, gout, dinout, addsub, done};
    endfunction

    function automatic logic [22:0] ctrlNow();
        return {IRin, Rin, Rout, Ain, Gin, Gout, DINout, AddSub, Done};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic run, input logic [8:0] ir, input logic gnz);
        Run  = run;
        IR   = ir;
        G_nz = gnz;
    endtask

    task automatic nextCycle();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Resetn = 1'b0;
        DIN    = 9'd0;
        A      = 9'd0;
        G      = 9'd0;
        for (int i = 0; i < 8; i++) R[i] = 9'd0;
        applyStimulus(1'b1, 9'b000_000_000, 1'b0);
        #2;
        checkOutput("reset_tstep", 32'(Tstep), 32'(T0));
        checkOutput("reset_ctrl_run1", 32'(ctrlNow()), 32'd0);
        nextCycle();
        checkOutput("reset_hold_tstep", 32'(Tstep), 32'(T0));
        Run    = 1'b0;
        Resetn = 1'b1;
        #1;
        checkOutput("idle_ctrl", 32'(ctrlNow()), 32'd0);
        nextCycle();
        checkOutput("idle_tstep", 32'(Tstep), 32'(T0));

        // mv R0,R1
        R[1] = 9'd10;
        applyStimulus(1'b1, 9'b000_000_001, 1'b0);
        #1;
        checkOutput("mv_t0", 32'({Tstep, ctrlNow()}), 32'({T0, mkCtrl(1, 0, 0, 0, 0, 0, 0, 0, 0)}));
        nextCycle();
        Run = 1'b0;
        checkOutput("mv_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 8'b0000_0001, 8'b0000_0010, 0, 0, 0, 0, 0, 1)}));
        nextCycle();
        checkOutput("mv_r0", 32'(R[0]), 32'd10);
        checkOutput("mv_back_t0", 32'({Tstep, ctrlNow()}), 32'({T0, 23'd0}));

        // mvi R0,5
        DIN = 9'd5;
        applyStimulus(1'b1, 9'b001_000_001, 1'b0);
        nextCycle();
        Run = 1'b0;
        checkOutput("mvi_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 8'b0000_0001, 0, 0, 0, 0, 1, 0, 1)}));
        nextCycle();
        checkOutput("mvi_r0", 32'(R[0]), 32'd5);

        // sub R1,R0 with Run toggled mid-instruction
        R[1] = 9'd10;
        applyStimulus(1'b1, 9'b011_001_000, 1'b0);
        nextCycle();
        Run = 1'b0;
        checkOutput("sub_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 0, 8'b0000_0010, 1, 0, 0, 0, 0, 0)}));
        nextCycle();
        Run = 1'b1;
        checkOutput("sub_t2", 32'({Tstep, ctrlNow()}),
                    32'({T2, mkCtrl(0, 0, 8'b0000_0001, 0, 1, 0, 0, 1, 0)}));
        nextCycle();
        Run = 1'b0;
        checkOutput("sub_t3", 32'({Tstep, ctrlNow()}),
                    32'({T3, mkCtrl(0, 8'b0000_0010, 0, 0, 0, 1, 0, 0, 1)}));
        nextCycle();
        checkOutput("sub_r1", 32'(R[1]), 32'd5);
        checkOutput("sub_done_once", 32'({Tstep, Done}), 32'({T0, 1'b0}));

        // add R5,R5 doubles R5
        R[5] = 9'd3;
        applyStimulus(1'b1, 9'b010_101_101, 1'b0);
        nextCycle();
        Run = 1'b0;
        nextCycle();
        checkOutput("add_t2", 32'({Tstep, ctrlNow()}),
                    32'({T2, mkCtrl(0, 0, 8'b0010_0000, 0, 1, 0, 0, 0, 0)}));
        nextCycle();
        nextCycle();
        checkOutput("add_r5", 32'(R[5]), 32'd6);

        // Reset during T2 of sub aborts at once
        applyStimulus(1'b1, 9'b011_001_000, 1'b0);
        nextCycle();
        Run = 1'b0;
        nextCycle();
        checkOutput("abort_pre_t2", 32'(Tstep), 32'(T2));
        Resetn = 1'b0;
        #1;
        checkOutput("abort_now", 32'({Tstep, ctrlNow()}), 32'({T0, 23'd0}));
        nextCycle();
        Resetn = 1'b1;
        nextCycle();
        checkOutput("abort_release_idle", 32'({Tstep, ctrlNow()}), 32'({T0, 23'd0}));
        checkOutput("abort_r1_kept", 32'(R[1]), 32'd5);

        // mvnz R2,R3 with G_nz low then high
        R[2] = 9'd0;
        R[3] = 9'd7;
        applyStimulus(1'b1, 9'b100_010_011, 1'b0);
        nextCycle();
        Run = 1'b0;
        checkOutput("mvnz_gz0_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 0, 0, 0, 0, 0, 0, 0, 1)}));
        nextCycle();
        checkOutput("mvnz_gz0_r2", 32'(R[2]), 32'd0);
        applyStimulus(1'b1, 9'b100_010_011, 1'b1);
        nextCycle();
        Run = 1'b0;
        checkOutput("mvnz_gz1_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 8'b0000_0100, 8'b0000_1000, 0, 0, 0, 0, 0, 1)}));
        nextCycle();
        checkOutput("mvnz_gz1_r2", 32'(R[2]), 32'd7);

        // Illegal opcode, then back-to-back mv R4,R1 with Run held high
        applyStimulus(1'b1, 9'b111_000_000, 1'b0);
        nextCycle();
        checkOutput("illegal_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 0, 0, 0, 0, 0, 0, 0, 1)}));
        nextCycle();
        IR = 9'b000_100_001;
        checkOutput("b2b_t0", 32'({Tstep, ctrlNow()}), 32'({T0, mkCtrl(1, 0, 0, 0, 0, 0, 0, 0, 0)}));
        nextCycle();
        Run = 1'b0;
        checkOutput("b2b_mv_t1", 32'({Tstep, ctrlNow()}),
                    32'({T1, mkCtrl(0, 8'b0001_0000, 8'b0000_0010, 0, 0, 0, 0, 0, 1)}));
        nextCycle();
        checkOutput("b2b_r4", 32'(R[4]), 32'd5);
        checkOutput("b2b_idle", 32'({Tstep, ctrlNow()}), 32'({T0, 23'd0}));

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
